mac_array_stream: RTL and testbench
===================================

Name: mac_array_stream

Overview:
- Parametrised successor to the fixed 4x64-bit MAC array.
- Streams activation and weight vectors over NUM_CH DMA channels with valid/ready handshake. Accumulates a signed fixed-point dot product over a run-time number of beats, then adds a bias and saturates.
- Presents the result on a held valid/ready output port.
- Sits between the DMA stream fabric and the VAE layer post-processing / writeback.

Parameters:
- NUM_CH, 4, number of DMA channels per operand bus.
- CH_W, 64, bits per DMA channel.
- ELEM_W, 16, signed element width (activations, weights, bias, result).
- FRAC_W, 8, fractional bits of all ELEM_W quantities (default format Q8.8).
- ACC_W, 48, accumulator width; must be at least 2*ELEM_W + clog2(P) + LEN_W.
- LEN_W, 8, width of the beat-count input.
- Derived: P = NUM_CH*CH_W/ELEM_W elements per beat (default 16). NUM_CH*CH_W must be a multiple of ELEM_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin an operation; sampled only in IDLE
- len  in  LEN_W  beats to accumulate; latched on start
- bias  in  ELEM_W  signed bias; latched on start
- clr  in  1  synchronous abort; same effect as rst
- act_data  in  NUM_CH*CH_W  P packed signed activations; element k at bits [k*ELEM_W +: ELEM_W]
- wgt_data  in  NUM_CH*CH_W  P packed signed weights, same packing
- in_valid  in  1  act_data/wgt_data beat valid
- in_ready  out  1  block accepts a beat
- dot_product  out  ELEM_W  saturated result
- out_valid  out  1  dot_product valid
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst or clr, synchronous):
  - State goes to IDLE.
  - in_ready, out_valid, busy, dot_product, accumulator, beat counter and pipeline valid all go to 0.
  - clr has priority over every other input. Applied mid-operation it discards all partial results, and no out_valid follows.
- States: IDLE, ACC, DRAIN1, DRAIN2, OUT.
- IDLE:
  - On start: latch len and bias, clear the accumulator.
  - If len == 0, go to DRAIN2, which produces the saturated bias. Otherwise go to ACC.
  - start in any other state is ignored.
- ACC:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready.
  - Stage 1: all P products act[k]*wgt[k] are formed at full 2*ELEM_W width, sign-extended to ACC_W and summed. The sum is registered with a valid flag on the clock edge that accepts the beat.
  - Stage 2: on the next edge, the registered sum is added into the accumulator when the flag is set.
  - The beat counter increments per accepted beat.
  - When the accepted beat is number len, go to DRAIN1; in_ready drops the following cycle.
  - in_valid gaps stall the operation with no penalty.
- DRAIN1: the last stage-1 sum lands in the accumulator. Go to DRAIN2.
- DRAIN2 (finalize):
  - r = (acc + (sign-extended bias << FRAC_W)) >>> FRAC_W. The shift is arithmetic and truncates toward negative infinity.
  - Saturate r to [-(2^(ELEM_W-1)), 2^(ELEM_W-1)-1].
  - Register the result into dot_product. Go to OUT.
- OUT:
  - out_valid = 1.
  - dot_product is held stable while out_ready is low.
  - On out_valid && out_ready, go to IDLE; out_valid drops next cycle. dot_product keeps its value until the next finalize.
- Latency:
  - The last beat is accepted in cycle t; out_valid is high from cycle t+3.
  - For len == 0, start in cycle t gives out_valid high from cycle t+2.
- Throughput: one beat per cycle in ACC. No new operation starts until the result is consumed.
- Simultaneous events: clr overrides start, in_valid and out_ready in the same cycle. start in the same cycle as an OUT handshake is ignored.

Optional Feature:
- Macro: MAC_ARRAY_RELU_EN.
- Defined: after saturation, a negative result is replaced by 0 before it is registered into dot_product. Latency is unchanged.
- Undefined: the signed saturated result passes through unmodified.

Test Plan:
- Unity dot product: all elements 16'h0100, len=1, bias=0 -> dot_product=16'h1000, out_valid at t+3.
- Saturation: all elements 16'h5555, len=1, bias=0 -> dot_product=16'h7FFF. With act=16'h8000, wgt=16'h7FFF -> 16'h8000 (16'h0000 with MAC_ARRAY_RELU_EN).
- Negative accumulation with bias: act=16'hFF00, wgt=16'h0100, len=4, bias=16'h0080 -> 16'hC080 (16'h0000 with MAC_ARRAY_RELU_EN).
- Backpressure:
  - in_valid pattern 1,0,0,1,1,0,1 with len=4 (elements 16'h0100) -> 16'h4000.
  - out_ready held low 5 cycles -> out_valid and dot_product stay stable; exactly one handshake occurs.
- len=0 with bias=16'h0300 -> no beats accepted (in_ready stays 0), dot_product=16'h0300, out_valid at t+2.
- Abort: clr pulsed after 2 of len=8 beats -> IDLE next cycle, busy=0, no out_valid. A following len=1 unity run gives 16'h1000, with no carry-over from the aborted run.

Source files
------------

// File: rtl/mac_array_stream_if.sv
// Stream/control bundle for mac_array_stream: operand beats in, saturated result out.
// The slave modport is the MAC block; the master modport is the DMA/control side.
interface mac_array_stream_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 64,
   parameter int ELEM_W = 16,
   parameter int LEN_W  = 8
);
   logic                     start;
   logic [LEN_W-1:0]         len;
   logic [ELEM_W-1:0]        bias;
   logic                     clr;
   logic [NUM_CH*CH_W-1:0]   act_data;
   logic [NUM_CH*CH_W-1:0]   wgt_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [ELEM_W-1:0]        dot_product;
   logic                     out_valid;
   logic                     out_ready;
   logic                     busy;

   modport master (
      output start, len, bias, clr, act_data, wgt_data, in_valid, out_ready,
      input  in_ready, dot_product, out_valid, busy
   );

   modport slave (
      input  start, len, bias, clr, act_data, wgt_data, in_valid, out_ready,
      output in_ready, dot_product, out_valid, busy
   );
endinterface

// File: rtl/mac_array_stream.sv
// Streaming signed fixed-point MAC: P-wide dot product per beat, bias add, saturate.
// Optional MAC_ARRAY_RELU_EN clamps negative results to zero before registering.
module mac_array_stream #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 64,
   parameter int ELEM_W = 16,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = 48,
   parameter int LEN_W  = 8
) (
   input logic              clk,
   input logic              rst,
   mac_array_stream_if.slave s
);
   localparam int P  = NUM_CH * CH_W / ELEM_W;
   localparam int PW = 2 * ELEM_W;

   typedef enum logic [2:0] {IDLE, ACC, DRAIN1, DRAIN2, OUT} state_t;

   state_t                    r_state;
   logic [LEN_W-1:0]          r_len;
   logic [LEN_W-1:0]          r_cnt;
   logic signed [ELEM_W-1:0]  r_bias;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [ACC_W-1:0]   r_s1_sum;
   logic                      r_s1_vld;
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic                      r_busy;
   logic [ELEM_W-1:0]         r_dot;

   logic                      w_beat;
   logic                      w_last;
   logic signed [ACC_W-1:0]   w_sum;
   logic signed [ACC_W-1:0]   w_bias_ext;
   logic signed [ACC_W-1:0]   w_biased;
   logic signed [ACC_W-1:0]   w_shift;
   logic [ACC_W-ELEM_W:0]     w_hi;
   logic [ELEM_W-1:0]         w_sat;
   logic [ELEM_W-1:0]         w_res;

   assign w_beat = r_in_ready && s.in_valid;
   assign w_last = ((LEN_W+1)'(r_cnt) + (LEN_W+1)'(1)) == (LEN_W+1)'(r_len);

   always_comb begin
      logic signed [PW-1:0] w_prod;
      w_prod = '0;
      w_sum  = '0;
      for (int unsigned k = 0; k < P; k++) begin
         w_prod = $signed(s.act_data[k*ELEM_W +: ELEM_W]) * $signed(s.wgt_data[k*ELEM_W +: ELEM_W]);
         w_sum  = w_sum + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
      end
   end

   // Bias is aligned to the accumulator's 2*FRAC_W fraction before the arithmetic down-shift.
   assign w_bias_ext = {{(ACC_W-ELEM_W){r_bias[ELEM_W-1]}}, r_bias};
   assign w_biased   = r_acc + (w_bias_ext <<< FRAC_W);
   assign w_shift    = w_biased >>> FRAC_W;
   assign w_hi       = w_shift[ACC_W-1:ELEM_W-1];

   always_comb begin
      if ((&w_hi) || !(|w_hi)) begin
         w_sat = w_shift[ELEM_W-1:0];
      end else if (w_shift[ACC_W-1]) begin
         w_sat = {1'b1, {(ELEM_W-1){1'b0}}};
      end else begin
         w_sat = {1'b0, {(ELEM_W-1){1'b1}}};
      end
`ifdef MAC_ARRAY_RELU_EN
      w_res = w_sat[ELEM_W-1] ? '0 : w_sat;
`else
      w_res = w_sat;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || s.clr) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_bias      <= '0;
         r_acc       <= '0;
         r_s1_sum    <= '0;
         r_s1_vld    <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_dot       <= '0;
      end else begin
         r_s1_vld <= w_beat;
         if (w_beat) r_s1_sum <= w_sum;
         if (r_s1_vld) r_acc <= r_acc + r_s1_sum;
         case (r_state)
            IDLE: begin
               if (s.start) begin
                  r_len  <= s.len;
                  r_bias <= s.bias;
                  r_acc  <= '0;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (s.len == '0) begin
                     r_state <= DRAIN2;
                  end else begin
                     r_state    <= ACC;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            ACC: begin
               if (w_beat) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_in_ready <= 1'b0;
                     r_state    <= DRAIN1;
                  end
               end
            end
            DRAIN1: r_state <= DRAIN2;
            DRAIN2: begin
               r_dot       <= w_res;
               r_out_valid <= 1'b1;
               r_state     <= OUT;
            end
            OUT: begin
               if (s.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s.in_ready    = r_in_ready;
   assign s.out_valid   = r_out_valid;
   assign s.busy        = r_busy;
   assign s.dot_product = r_dot;
endmodule

// File: tb/tb_mac_array_stream.sv
// Self-checking bench for mac_array_stream: directed cases plus randomized runs against
// an integer dot-product model. Honours MAC_ARRAY_RELU_EN in its expectations.
module tb_mac_array_stream;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 64;
   localparam int ELEM_W = 16;
   localparam int LEN_W  = 8;
   localparam int P      = 16;
   localparam int BW     = NUM_CH * CH_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_array_stream_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ELEM_W(ELEM_W), .LEN_W(LEN_W)) bus ();

   mac_array_stream #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .ELEM_W(ELEM_W), .FRAC_W(8), .ACC_W(48), .LEN_W(LEN_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s  (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rnd_elem();
      logic signed [15:0] v;
      v = 16'($urandom);
      return 16'(v >>> $urandom_range(0, 7));
   endfunction

   function automatic logic [15:0] model_result(input longint acc, input logic [15:0] b);
      longint r;
      r = (acc + longint'($signed(b)) * 256) >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`ifdef MAC_ARRAY_RELU_EN
      if (r < 0) r = 0;
`endif
      return 16'(r);
   endfunction

   task automatic make_beat(input int dmode, input logic [15:0] fa, input logic [15:0] fw,
                            output logic [BW-1:0] a, output logic [BW-1:0] w);
      for (int k = 0; k < P; k++) begin
         a[k*16 +: 16] = (dmode == 0) ? fa : rnd_elem();
         w[k*16 +: 16] = (dmode == 0) ? fw : rnd_elem();
      end
   endtask

   // vpat: 0 = always valid, 1 = repeating 1,0,0,1,1,0,1, 2 = random gaps
   task automatic run_op(input int L, input logic [15:0] b, input int vpat, input int hold,
                         input int dmode, input logic [15:0] fa, input logic [15:0] fw,
                         input bit use_fixed, input logic [15:0] fixed, input string tag);
      logic [BW-1:0] a, w;
      logic [15:0]   exp;
      longint        acc;
      int            sent, p, guard, c_start, c_last, hs;
      bit            v;
      logic [6:0]    pat;
      pat = 7'b1011001;
      acc = 0;
      sent = 0;
      p = 0;
      guard = 0;
      hs = 0;
      bus.start = 1'b1;
      bus.len   = LEN_W'(L);
      bus.bias  = b;
      c_start   = cyc;
      c_last    = cyc;
      tick();
      bus.start = 1'b0;
      while (sent < L && guard < 500) begin
         case (vpat)
            0:       v = 1'b1;
            1:       v = pat[p % 7];
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         make_beat(dmode, fa, fw, a, w);
         bus.act_data = a;
         bus.wgt_data = w;
         bus.in_valid = v;
         if (v && bus.in_ready) begin
            for (int k = 0; k < P; k++)
               acc += longint'($signed(a[k*16 +: 16])) * longint'($signed(w[k*16 +: 16]));
            c_last = cyc;
            sent++;
         end
         p++;
         guard++;
         tick();
      end
      bus.in_valid = 1'b0;
      check({tag, "_beats"}, 32'(sent), 32'(L));
      check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
      guard = 0;
      while (bus.out_valid !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      check({tag, "_latency"}, 32'(cyc - ((L == 0) ? c_start : c_last)), (L == 0) ? 32'd2 : 32'd3);
      exp = use_fixed ? fixed : model_result(acc, b);
      check({tag, "_dot"}, 32'(bus.dot_product), 32'(exp));
      for (int h = 0; h < hold; h++) begin
         bus.out_ready = 1'b0;
         tick();
         check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, "_hold_dot"}, 32'(bus.dot_product), 32'(exp));
      end
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      if (bus.out_valid && bus.out_ready) hs++;
      tick();
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      check({tag, "_handshakes"}, 32'(hs), 32'd1);
      check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_dot_kept"}, 32'(bus.dot_product), 32'(exp));
      tick();
      check({tag, "_start_in_out_ignored"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [BW-1:0] a, w;
      logic [15:0]   e_neg_sat, e_neg_bias;
`ifdef MAC_ARRAY_RELU_EN
      e_neg_sat  = 16'h0000;
      e_neg_bias = 16'h0000;
`else
      e_neg_sat  = 16'h8000;
      e_neg_bias = 16'hC080;
`endif
      bus.start = 1'b0;
      bus.len = '0;
      bus.bias = '0;
      bus.clr = 1'b0;
      bus.act_data = '0;
      bus.wgt_data = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_dot", 32'(bus.dot_product), 32'd0);
      rst = 1'b0;
      tick();

      run_op(1, 16'h0000, 0, 0, 0, 16'h0100, 16'h0100, 1'b1, 16'h1000, "unity");
      run_op(1, 16'h0000, 0, 0, 0, 16'h5555, 16'h5555, 1'b1, 16'h7FFF, "sat_pos");
      run_op(1, 16'h0000, 0, 0, 0, 16'h8000, 16'h7FFF, 1'b1, e_neg_sat, "sat_neg");
      run_op(4, 16'h0080, 0, 0, 0, 16'hFF00, 16'h0100, 1'b1, e_neg_bias, "neg_bias");
      run_op(4, 16'h0000, 1, 5, 0, 16'h0100, 16'h0100, 1'b1, 16'h4000, "backpressure");
      run_op(0, 16'h0300, 0, 0, 0, 16'h0000, 16'h0000, 1'b1, 16'h0300, "len0");

      // Abort after two of eight beats; clr also overrides a concurrent start.
      bus.start = 1'b1;
      bus.len   = 8'd8;
      bus.bias  = 16'h0000;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         make_beat(0, 16'h0100, 16'h0100, a, w);
         bus.act_data = a;
         bus.wgt_data = w;
         bus.in_valid = 1'b1;
         check("abort_in_ready", 32'(bus.in_ready), 32'd1);
         tick();
      end
      bus.clr   = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.clr      = 1'b0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("abort_dot", 32'(bus.dot_product), 32'd0);
      for (int i = 0; i < 6; i++) begin
         check("abort_no_valid", 32'(bus.out_valid), 32'd0);
         tick();
      end
      run_op(1, 16'h0000, 0, 0, 0, 16'h0100, 16'h0100, 1'b1, 16'h1000, "post_abort");

      for (int n = 0; n < 10; n++) begin
         int L;
         L = (n % 3 == 2) ? int'($urandom_range(1, 40)) : int'($urandom_range(0, 6));
         run_op(L, rnd_elem(), 2, int'($urandom_range(0, 3)), 1, 16'h0000, 16'h0000,
                1'b0, 16'h0000, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
